// File: rtl/lvds_pattern_pkg.sv
// Shared definitions for the LVDS PRBS pattern generator and the TLP receive checker.
// Both ends build their word sequence from these helpers so the streams match bit for bit.
package lvds_pattern_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VALID,
        CHECK,
        POP,
        SETTLE,
        DONE
    } state_e;

    // Feedback taps for x^32 + x^22 + x^2 + x + 1 (bits 31, 21, 1, 0).
    localparam logic [31:0] PRBS_TAPS         = 32'h8020_0003;
    localparam logic [31:0] PRBS_SEED_DEFAULT = 32'hFFFF_FFFF;

    function automatic logic [31:0] prbs_next(input logic [31:0] lfsr);
        return {lfsr[30:0], ^(lfsr & PRBS_TAPS)};
    endfunction

    // Bit idx of an expected word repeats the LFSR state every 32 bits.
    function automatic logic prbs_expand_bit(input logic [31:0] lfsr, input int idx);
        logic [4:0] pos;
        pos = idx[4:0];
        return lfsr[pos];
    endfunction

endpackage

// File: rtl/tlp_rx_checker_if.sv
// Read port between the transceiver receive buffer and the checker.
// The master is the consumer that pops words; the slave is the buffer presenting them.
interface tlp_rx_checker_if #(
    parameter int TLP_WIDTH = 34
);
    logic [TLP_WIDTH-1:0] i_tlp;
    logic                 i_tlp_valid;
    logic                 o_tlp_rd;

    modport master (input i_tlp, input i_tlp_valid, output o_tlp_rd);
    modport slave  (output i_tlp, output i_tlp_valid, input o_tlp_rd);
endinterface

// File: rtl/prbs32_lfsr.sv
// 32-bit Fibonacci PRBS register with synchronous load and step enable.
// Shared between the pattern generator and the receive checker.
module prbs32_lfsr
    import lvds_pattern_pkg::*;
#(
    parameter logic [31:0] RESET_SEED = PRBS_SEED_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_arst,
    input  logic        i_load,
    input  logic        i_step,
    input  logic [31:0] i_seed,
    output logic [31:0] o_state
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and the order of statements cannot create races.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            o_state <= RESET_SEED;
        end else if (i_load) begin
            o_state <= i_seed;
        end else if (i_step) begin
            o_state <= prbs_next(o_state);
        end
    end

endmodule

// File: rtl/tlp_rx_checker.sv
// Drains received TLP words, compares them with the regenerated PRBS stream and
// reports word count, error count, first bad word, timeout and pass/fail.
module tlp_rx_checker
    import lvds_pattern_pkg::*;
#(
    parameter int          TLP_WIDTH      = 34,
    parameter int          NUM_TLP        = 20,
    parameter logic [31:0] PRBS_SEED      = PRBS_SEED_DEFAULT,
    parameter int          TIMEOUT_CYCLES = 65535
) (
    input  logic                 i_clk,
    input  logic                 i_arst,
    input  logic                 i_start,
    tlp_rx_checker_if.master     tlp_bus,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_pass,
    output logic                 o_timeout,
    output logic [15:0]          o_rx_cnt,
    output logic [15:0]          o_err_cnt,
    output logic [TLP_WIDTH-1:0] o_first_err
);

    localparam logic [15:0] NUM_TLP_C      = 16'(NUM_TLP);
    localparam logic [15:0] TIMEOUT_LAST_C = 16'(TIMEOUT_CYCLES - 1);

    state_e               state;
    state_e               state_next;
    logic                 start_run;
    logic                 timeout_hit;
    logic                 mismatch;
    logic                 tlp_rd_q;
    logic [15:0]          idle_cnt;
    logic [31:0]          lfsr;
    logic [TLP_WIDTH-1:0] expected_word;

    prbs32_lfsr #(
        .RESET_SEED (PRBS_SEED)
    ) u_lfsr (
        .i_clk   (i_clk),
        .i_arst  (i_arst),
        .i_load  (start_run),
        .i_step  (state == POP),
        .i_seed  (PRBS_SEED),
        .o_state (lfsr)
    );

    always_comb begin
        for (int i = 0; i < TLP_WIDTH; i++) begin
            expected_word[i] = prbs_expand_bit(lfsr, i);
        end
    end

    assign mismatch         = (state == CHECK) && (tlp_bus.i_tlp != expected_word);
    assign tlp_bus.o_tlp_rd = tlp_rd_q;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        start_run   = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (i_start) begin
                    start_run  = 1'b1;
                    state_next = WAIT_VALID;
                end
            end
            WAIT_VALID: begin
                if (tlp_bus.i_tlp_valid) begin
                    state_next = CHECK;
                end else if (idle_cnt == TIMEOUT_LAST_C) begin
                    timeout_hit = 1'b1;
                    state_next  = DONE;
                end
            end
            CHECK:   state_next = POP;
            POP:     state_next = SETTLE;
            SETTLE:  state_next = (o_rx_cnt == NUM_TLP_C) ? DONE : WAIT_VALID;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they line up with it.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state       <= IDLE;
            tlp_rd_q    <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_pass      <= 1'b0;
            o_timeout   <= 1'b0;
            o_rx_cnt    <= '0;
            o_err_cnt   <= '0;
            o_first_err <= '0;
            idle_cnt    <= '0;
        end else begin
            state    <= state_next;
            tlp_rd_q <= (state_next == POP);
            o_busy   <= state_next inside {WAIT_VALID, CHECK, POP, SETTLE};
            o_done   <= (state_next == DONE);
            o_pass   <= (state_next == DONE) && !timeout_hit && !o_timeout &&
                        (o_err_cnt == 16'd0) && (o_rx_cnt == NUM_TLP_C);

            if (start_run) begin
                o_timeout   <= 1'b0;
                o_rx_cnt    <= '0;
                o_err_cnt   <= '0;
                o_first_err <= '0;
                idle_cnt    <= '0;
            end else begin
                if (state == WAIT_VALID && !tlp_bus.i_tlp_valid) begin
                    idle_cnt <= idle_cnt + 16'd1;
                end
                if (timeout_hit) begin
                    o_timeout <= 1'b1;
                end
                if (mismatch) begin
                    if (o_err_cnt != 16'hFFFF) begin
                        o_err_cnt <= o_err_cnt + 16'd1;
                    end
                    if (o_err_cnt == 16'd0) begin
                        o_first_err <= tlp_bus.i_tlp;
                    end
                end
                if (state == POP) begin
                    o_rx_cnt <= o_rx_cnt + 16'd1;
                    idle_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_tlp_rx_checker.sv
// Scoreboard bench for tlp_rx_checker: a behavioural FIFO feeds PRBS words (some
// corrupted, some gapped) and a monitor compares each finished run with the model.
module tb_tlp_rx_checker;

    localparam int          W    = 34;
    localparam int          NUM  = 20;
    localparam int          TMO  = 100;
    localparam logic [31:0] SEED = 32'hFFFF_FFFF;

    typedef struct {
        bit           pass;
        bit           timeout;
        int           rx;
        int           err;
        logic [W-1:0] first_err;
        bit           spacing;
    } exp_t;

    logic          i_clk = 1'b0;
    logic          i_arst;
    logic          i_start;
    logic          o_busy, o_done, o_pass, o_timeout;
    logic [15:0]   o_rx_cnt, o_err_cnt;
    logic [W-1:0]  o_first_err;

    tlp_rx_checker_if #(.TLP_WIDTH(W)) tlp_bus ();

    tlp_rx_checker #(
        .TLP_WIDTH      (W),
        .NUM_TLP        (NUM),
        .PRBS_SEED      (SEED),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk       (i_clk),
        .i_arst      (i_arst),
        .i_start     (i_start),
        .tlp_bus     (tlp_bus),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_pass      (o_pass),
        .o_timeout   (o_timeout),
        .o_rx_cnt    (o_rx_cnt),
        .o_err_cnt   (o_err_cnt),
        .o_first_err (o_first_err)
    );

    always #5 i_clk = ~i_clk;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           cycle    = 0;
    int           run_rd   = 0;
    int           last_rd  = 0;
    int           hold_cnt = 0;
    int           max_gap  = 0;
    int           corrupt_bit[NUM];
    logic [W-1:0] buf_q[$];
    exp_t         exp_q[$];

    initial forever begin
        @(posedge i_clk);
        cycle++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Reference sequence straight from the polynomial: shift left, feed back taps 31/21/1/0.
    function automatic logic [W-1:0] ref_word(input int k);
        logic [31:0]  s;
        logic [31:0]  fb;
        logic [W-1:0] w;
        s = SEED;
        for (int n = 0; n < k; n++) begin
            fb = ((s >> 31) ^ (s >> 21) ^ (s >> 1) ^ s) & 32'd1;
            s  = (s << 1) | fb;
        end
        for (int i = 0; i < W; i++) w[i] = s[i % 32];
        return w;
    endfunction

    // Receive buffer model: pops on o_tlp_rd, optionally holds the next word back.
    initial begin
        tlp_bus.i_tlp       = '0;
        tlp_bus.i_tlp_valid = 1'b0;
        forever begin
            @(negedge i_clk);
            if (tlp_bus.o_tlp_rd) begin
                check("pop_while_valid", 64'(tlp_bus.i_tlp_valid), 64'd1);
                if (buf_q.size() > 0) void'(buf_q.pop_front());
                hold_cnt = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            end else if (hold_cnt > 0) begin
                hold_cnt--;
            end
            tlp_bus.i_tlp_valid = (buf_q.size() > 0) && (hold_cnt == 0);
            tlp_bus.i_tlp       = (buf_q.size() > 0) ? buf_q[0] : '0;
        end
    end

    // Monitor: spacing of pops and the end-of-run result against the scoreboard.
    initial begin
        logic done_q;
        exp_t e;
        done_q = 1'b0;
        forever begin
            @(negedge i_clk);
            if (tlp_bus.o_tlp_rd) begin
                if (exp_q.size() > 0 && exp_q[0].spacing && run_rd > 0)
                    check("rd_spacing", 64'(cycle - last_rd), 64'd4);
                run_rd++;
                last_rd = cycle;
            end
            if (o_done && !done_q) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    e = exp_q.pop_front();
                    check("pass",      64'(o_pass),      64'(e.pass));
                    check("timeout",   64'(o_timeout),   64'(e.timeout));
                    check("rx_cnt",    64'(o_rx_cnt),    64'(e.rx));
                    check("err_cnt",   64'(o_err_cnt),   64'(e.err));
                    check("first_err", 64'(o_first_err), 64'(e.first_err));
                    check("rd_pulses", 64'(run_rd),      64'(e.rx));
                    check("busy_low",  64'(o_busy),      64'd0);
                    // DONE follows WAIT_VALID entry (POP + 2) by exactly TMO cycles.
                    if (e.timeout && e.rx > 0)
                        check("timeout_latency", 64'(cycle - last_rd), 64'(TMO + 2));
                end
            end
            done_q = o_done && !i_arst;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_rd"},        64'(tlp_bus.o_tlp_rd), 64'd0);
        check({tag, "_busy"},      64'(o_busy),           64'd0);
        check({tag, "_done"},      64'(o_done),           64'd0);
        check({tag, "_pass"},      64'(o_pass),           64'd0);
        check({tag, "_timeout"},   64'(o_timeout),        64'd0);
        check({tag, "_rx_cnt"},    64'(o_rx_cnt),         64'd0);
        check({tag, "_err_cnt"},   64'(o_err_cnt),        64'd0);
        check({tag, "_first_err"}, 64'(o_first_err),      64'd0);
    endtask

    task automatic load_and_start(input int n_supply, input int gap, input bit spacing,
                                  input bit push_exp);
        exp_t         e;
        logic [W-1:0] w;
        e = '{pass: 1'b0, timeout: 1'b0, rx: n_supply, err: 0, first_err: '0, spacing: spacing};
        buf_q.delete();
        hold_cnt = 0;
        max_gap  = gap;
        for (int k = 0; k < n_supply; k++) begin
            w = ref_word(k);
            if (corrupt_bit[k] >= 0) begin
                w[corrupt_bit[k]] = ~w[corrupt_bit[k]];
                if (e.err == 0) e.first_err = w;
                e.err++;
            end
            buf_q.push_back(w);
        end
        e.timeout = (n_supply < NUM);
        e.pass    = (e.err == 0) && !e.timeout;
        if (push_exp) exp_q.push_back(e);
        run_rd  = 0;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        check("busy_after_start", 64'(o_busy), 64'd1);
        check("done_after_start", 64'(o_done), 64'd0);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!o_done && n < 3000) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_done) fail_now({tag, "_done_wait_expired"});
        repeat (3) @(negedge i_clk);
    endtask

    task automatic clear_corruption();
        for (int k = 0; k < NUM; k++) corrupt_bit[k] = -1;
    endtask

    initial begin
        int a, b, n;
        i_arst  = 1'b1;
        i_start = 1'b0;
        clear_corruption();
        repeat (3) @(negedge i_clk);
        check_all_zero("reset");
        i_arst = 1'b0;
        repeat (2) @(negedge i_clk);

        // Clean back-to-back stream.
        load_and_start(NUM, 0, 1'b1, 1'b1);
        wait_done("clean");

        // Word 7 has bit 0 flipped.
        corrupt_bit[7] = 0;
        load_and_start(NUM, 0, 1'b1, 1'b1);
        wait_done("corrupt7");
        clear_corruption();

        // Only 5 words ever arrive.
        load_and_start(5, 0, 1'b1, 1'b1);
        wait_done("timeout");

        // Random gaps, plus a start pulse mid-run that must be ignored.
        load_and_start(NUM, 10, 1'b0, 1'b1);
        repeat (30) @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_done("gapped");

        // Two random corruptions with random gaps.
        a = int'($urandom_range(9, 0));
        b = int'($urandom_range(NUM - 1, 10));
        corrupt_bit[a] = int'($urandom_range(W - 1, 0));
        corrupt_bit[b] = int'($urandom_range(W - 1, 0));
        load_and_start(NUM, 5, 1'b0, 1'b1);
        wait_done("random_corrupt");
        clear_corruption();

        // Reset after the third pop, then a clean rerun.
        load_and_start(NUM, 0, 1'b1, 1'b0);
        n = 0;
        while (run_rd < 3 && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (run_rd < 3) fail_now("reset_mid_run_wait_expired");
        #2 i_arst = 1'b1;
        #1 check_all_zero("mid_run_reset");
        buf_q.delete();
        repeat (3) @(negedge i_clk);
        check("no_rd_in_reset", 64'(run_rd), 64'd3);
        i_arst = 1'b0;
        repeat (2) @(negedge i_clk);
        load_and_start(NUM, 0, 1'b1, 1'b1);
        wait_done("after_reset");

        if (exp_q.size() != 0) fail_now("scoreboard_not_drained");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
